// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: refills one direct-mapped cache block from word-wide memory.
// It fetches WORDS beats over a req/ack handshake, assembles them into a cache
// line, and presents the line with a one-cycle line_valid pulse.
// Optional build macro: CRITICAL_WORD_FIRST_EN. It fetches the missed word first,
// wraps within the block, and pulses crit_valid/crit_data after the first beat.
//
// state | meaning
// IDLE  | waiting for miss_req; base/offset latched on the strobe
// FETCH | one word per acked beat, mem_req held until the last ack
// DONE  | line_valid pulse with line_data/line_addr, then back to IDLE
module cache_refill_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int WORDS  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      miss_req,
    input  logic [ADDR_W-1:0]         miss_addr,
    output logic                      busy,
    output logic                      mem_req,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [DATA_W-1:0]         mem_rdata,
    input  logic                      mem_ack,
    output logic [WORDS*DATA_W-1:0]   line_data,
    output logic [ADDR_W-1:0]         line_addr,
    output logic                      line_valid,
    output logic                      crit_valid,
    output logic [DATA_W-1:0]         crit_data
);

    localparam int OFF_W = $clog2(WORDS);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [OFF_W-1:0]         cnt_q, cnt_d;
    logic [OFF_W-1:0]         idx;
    logic [ADDR_W-OFF_W-1:0]  base_q;
    logic [WORDS*DATA_W-1:0]  line_data_q;
    logic [ADDR_W-1:0]        line_addr_q;
    logic                     beat;
    logic                     last_beat;

    // Next-state and handshake outputs; mem_req derives from state so reset drops it at once.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        busy       = 1'b0;
        mem_req    = 1'b0;
        line_valid = 1'b0;
        beat       = 1'b0;
        last_beat  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (miss_req) state_d = S_FETCH;
            end
            S_FETCH: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                if (mem_ack) begin
                    beat  = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == OFF_W'(WORDS - 1)) begin
                        last_beat = 1'b1;
                        state_d   = S_DONE;
                    end
                end
            end
            S_DONE: begin
                busy       = 1'b1;
                line_valid = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and beat counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Block base latch and line assembly; slots persist across refills.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q      <= '0;
            line_data_q <= '0;
            line_addr_q <= '0;
        end else begin
            if (state_q == S_IDLE && miss_req) base_q <= miss_addr[ADDR_W-1:OFF_W];
            if (beat) line_data_q[idx*DATA_W +: DATA_W] <= mem_rdata;
            if (last_beat) line_addr_q <= {base_q, {OFF_W{1'b0}}};
        end
    end

    assign mem_addr  = mem_req ? {base_q, idx} : '0;
    assign line_data = line_data_q;
    assign line_addr = line_addr_q;

`ifdef CRITICAL_WORD_FIRST_EN
    logic [OFF_W-1:0]  off_q;
    logic              crit_valid_q;
    logic [DATA_W-1:0] crit_data_q;

    // Offset arithmetic is OFF_W bits wide, so the fetch wraps inside the block.
    assign idx = off_q + cnt_q;

    // Missed-word offset latch and critical-word pulse after the first accepted beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            off_q        <= '0;
            crit_valid_q <= 1'b0;
            crit_data_q  <= '0;
        end else begin
            if (state_q == S_IDLE && miss_req) off_q <= miss_addr[OFF_W-1:0];
            crit_valid_q <= beat && (cnt_q == '0);
            if (beat && (cnt_q == '0)) crit_data_q <= mem_rdata;
        end
    end

    assign crit_valid = crit_valid_q;
    assign crit_data  = crit_data_q;
`else
    logic unused_off;

    assign idx        = cnt_q;
    assign unused_off = ^miss_addr[OFF_W-1:0];
    assign crit_valid = 1'b0;
    assign crit_data  = '0;
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: refill order, latency, stalls, ignored
// requests, async reset mid-fetch, and the critical-word-first variant.
module tb_cache_refill_ctrl;

    logic          clk = 1'b0;
    logic          reset;
    logic          miss_req;
    logic [9:0]    miss_addr;
    logic          busy;
    logic          mem_req;
    logic [9:0]    mem_addr;
    logic [31:0]   mem_rdata;
    logic          mem_ack;
    logic [127:0]  line_data;
    logic [9:0]    line_addr;
    logic          line_valid;
    logic          crit_valid;
    logic [31:0]   crit_data;

    int n_chk = 0;
    int n_err = 0;

    cache_refill_ctrl #(.ADDR_W(10), .DATA_W(32), .WORDS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .miss_req   (miss_req),
        .miss_addr  (miss_addr),
        .busy       (busy),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .line_data  (line_data),
        .line_addr  (line_addr),
        .line_valid (line_valid),
        .crit_valid (crit_valid),
        .crit_data  (crit_data)
    );

    always #5 clk = ~clk;

    // memory returns A0000000 + word address
    assign mem_rdata = 32'hA000_0000 + {22'b0, mem_addr};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_refill(input logic [9:0] addr, input int period, input bit inject);
        logic [9:0]   base;
        logic [1:0]   off;
        logic [9:0]   got[$];
        logic [9:0]   exp_a;
        logic [127:0] exp_line;
        logic [31:0]  cv_data;
        logic [9:0]   prev_addr;
        logic         prev_req, prev_ack;
        int           lv_cnt, lv_cyc, cv_cnt, cv_cyc, first_ack, after;
        bit           done;
        base = {addr[9:2], 2'b00};
        off  = addr[1:0];
        for (int i = 0; i < 4; i++) exp_line[i*32 +: 32] = 32'hA000_0000 + 32'(base | 10'(i));
        lv_cnt = 0; lv_cyc = -1; cv_cnt = 0; cv_cyc = -1; first_ack = -1; after = 0;
        cv_data = '0; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0; done = 1'b0;
        @(negedge clk);
        miss_req  = 1'b1;
        miss_addr = addr;
        mem_ack   = 1'b0;
        for (int cyc = 1; cyc <= 80 && !done; cyc++) begin
            @(negedge clk);
            miss_req = inject && (cyc == 2 || cyc == 5);
            if (inject) miss_addr = 10'h3FC;
            mem_ack = ((cyc % period) == 0);
            #2;
            if (prev_req && !prev_ack) begin
                chk("req_held", mem_req, 1'b1);
                chk("addr_held", mem_addr, prev_addr);
            end
            if (mem_req && mem_ack) begin
                got.push_back(mem_addr);
                if (first_ack < 0) first_ack = cyc;
            end
            if (line_valid) begin
                lv_cnt++;
                lv_cyc = cyc;
                chk("line_addr", line_addr, base);
                chk("line_data", line_data, exp_line);
            end
            if (crit_valid) begin
                cv_cnt++;
                cv_cyc  = cyc;
                cv_data = crit_data;
            end
            prev_req = mem_req; prev_ack = mem_ack; prev_addr = mem_addr;
            if (lv_cnt > 0) begin
                after++;
                if (after >= 3) done = 1'b1;
            end
        end
        chk("timeout", done, 1'b1);
        chk("beats", got.size(), 4);
        for (int i = 0; i < got.size() && i < 4; i++) begin
`ifdef CRITICAL_WORD_FIRST_EN
            exp_a = base | 10'((32'(off) + i) % 4);
`else
            exp_a = base | 10'(i);
`endif
            chk("addr_order", got[i], exp_a);
        end
        chk("lv_pulses", lv_cnt, 1);
        if (period == 1) chk("latency", lv_cyc, 5);
        chk("busy_after", busy, 1'b0);
        chk("line_hold", line_data, exp_line);
`ifdef CRITICAL_WORD_FIRST_EN
        chk("crit_pulses", cv_cnt, 1);
        chk("crit_cycle", cv_cyc, first_ack + 1);
        chk("crit_data", cv_data, 32'hA000_0000 + 32'(addr));
`else
        chk("crit_pulses", cv_cnt, 0);
`endif
        mem_ack = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        miss_req  = 1'b0;
        miss_addr = '0;
        mem_ack   = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_addr", mem_addr, 10'h0);
        chk("rst_lv", line_valid, 1'b0);
        chk("rst_line", line_data, 128'h0);
        chk("rst_laddr", line_addr, 10'h0);
        chk("rst_cv", crit_valid, 1'b0);
        chk("rst_cdata", crit_data, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        do_refill(10'h05A, 1, 1'b0);
        do_refill(10'h05A, 1, 1'b1);
        do_refill(10'h3FC, 1, 1'b0);
        do_refill(10'h05A, 3, 1'b0);
        do_refill(10'h3FF, 1, 1'b0);
        do_refill(10'h3FF, 2, 1'b0);

        // ack while idle must not start anything
        @(negedge clk);
        mem_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #2;
            chk("idle_ack_req", mem_req, 1'b0);
            chk("idle_ack_busy", busy, 1'b0);
        end
        mem_ack = 1'b0;

        // async reset after two accepted beats
        @(negedge clk);
        miss_req  = 1'b1;
        miss_addr = 10'h05A;
        @(negedge clk);
        miss_req = 1'b0;
        mem_ack  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2;
        chk("pre_rst_req", mem_req, 1'b1);
        reset = 1'b1;
        #1;
        chk("async_req", mem_req, 1'b0);
        chk("async_busy", busy, 1'b0);
        chk("async_line", line_data, 128'h0);
        repeat (3) begin
            @(negedge clk);
            #2;
            chk("rst_no_lv", line_valid, 1'b0);
        end
        @(negedge clk);
        reset   = 1'b0;
        mem_ack = 1'b0;
        do_refill(10'h101, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
- Miss-handling responder on the memory side of the direct-mapped data cache.
- On a miss request it fetches one full cache block (WORDS x DATA_W) from word-wide main memory using a req/ack handshake, one word per accepted beat.
- It assembles the block into the line format the cache write port consumes, then presents it with a one-cycle valid pulse.

Parameters:
- ADDR_W, 10, word-address width shared with the cache address bus
- DATA_W, 32, memory word width
- WORDS, 4, words per block; power of two, >= 2; OFF_W = log2(WORDS)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- miss_req  input  1  cache miss strobe; sampled only in IDLE
- miss_addr  input  ADDR_W  word address that missed; low OFF_W bits = block offset
- busy  output  1  high in FETCH and DONE
- mem_req  output  1  memory read request, held until acked
- mem_addr  output  ADDR_W  word address of the current beat
- mem_rdata  input  DATA_W  memory read data, valid when mem_ack=1
- mem_ack  input  1  beat accepted; mem_rdata captured this edge
- line_data  output  WORDS*DATA_W  assembled block; word i at bits [DATA_W*i+DATA_W-1 : DATA_W*i]
- line_addr  output  ADDR_W  block base address (offset bits zero)
- line_valid  output  1  one-cycle pulse: line_data/line_addr valid for the cache write
- crit_valid  output  1  critical-word pulse (see Optional Feature)
- crit_data  output  DATA_W  critical word

Behaviour:
- Reset (async, any state): state=IDLE, beat counter=0, all outputs 0, including line_data and line_addr.
- The FSM has three states: IDLE, FETCH and DONE.
- IDLE:
  - mem_req=0, busy=0.
  - On miss_req=1 at an edge, latch base = miss_addr with the low OFF_W bits cleared, and latch off = miss_addr[OFF_W-1:0].
  - Clear the counter and go to FETCH.
- FETCH:
  - mem_req=1 and busy=1 throughout.
  - mem_addr = base | idx, where idx = counter (macro off).
  - At an edge with mem_ack=1, write mem_rdata into line slot idx and increment the counter.
  - On the ack with counter==WORDS-1, go to DONE.
  - mem_ack=0 stalls indefinitely with mem_req and mem_addr held stable.
- DONE:
  - line_valid=1 for exactly this cycle; line_addr=base; mem_req=0.
  - Next state is always IDLE.
- line_data and line_addr hold their last values until the next refill overwrites slots. Slots are not cleared between refills.
- mem_ack while mem_req=0 is ignored.
- miss_req outside IDLE, including the DONE cycle, is ignored and not queued. The cache must re-assert it.
- Latency with mem_ack tied high: miss_req sampled at edge E, FETCH beats at edges E+1 to E+WORDS, line_valid high during the cycle after edge E+WORDS. This is WORDS+1 cycles from the request edge.
- The counter wraps modulo WORDS; the offset arithmetic (off+counter) also wraps modulo WORDS and never carries into the base bits.
- Reset asserted mid-FETCH: mem_req drops immediately (asynchronously), the partial line is discarded, no line_valid occurs.

Optional Feature:
- Macro: CRITICAL_WORD_FIRST_EN
- Defined:
  - idx = (off + counter) mod WORDS, so the missed word is fetched first and the fetch wraps within the block.
  - On the first acked beat, crit_valid pulses for the following cycle with crit_data = that word.
  - line_valid timing is unchanged.
  - Every word still lands in its natural slot (slot idx).
- Undefined:
  - Fetch order is 0..WORDS-1.
  - crit_valid and crit_data are tied to 0.

Test Plan:
- Basic refill: reset, miss_addr=10'h05A, mem_ack tied 1, mem_rdata = 32'hA0000000+mem_addr -> mem_addr sequence 058,059,05A,05B; line_valid 5 cycles after request; line_addr=058; line_data = {A000005B,A000005A,A0000059,A0000058}.
- Stall: same request, mem_ack high only every third cycle -> mem_req and mem_addr stable during gaps; line_data identical to basic case; line_valid single pulse.
- Ignored request: assert miss_req=1 with addr 3FC during FETCH and during DONE -> no effect; after IDLE, a fresh miss_req to 3FC fetches 3FC..3FF.
- Async reset mid-fetch: assert reset after 2 acked beats -> mem_req=0 and busy=0 without waiting for a clock edge; no line_valid; next refill is correct.
- CRITICAL_WORD_FIRST_EN defined, miss_addr=10'h05A -> mem_addr order 05A,05B,058,059; crit_valid pulse with crit_data=A000005A one cycle after the first ack; line_data equals the basic case; without the macro, crit_valid stays 0.
- Edge offset (macro on): miss_addr=10'h3FF -> order 3FF,3FC,3FD,3FE; no carry into the base bits; line_addr=3FC.
